deserializer_param: RTL and testbench

// - Parametrised serial-to-parallel deserializer; successor to the fixed 8-bit block.
// - Collects WIDTH bits from a 1-bit stream (qualified by write_in) into one word.
// - Presents the word on data_out with a ready/ack handshake toward the stack side.
// - Double-buffered: a shift stage plus a holding register, so the next word can be

---
 rtl/deserializer_param_if.sv | 24 ++
 rtl/deserializer_param.sv | 123 ++++++++++++
 tb/tb_deserializer_param.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/deserializer_param_if.sv
// Bus bundle for deserializer_param: serial input side plus the word/ready/ack side.
// The slave modport is the deserializer; the master modport is its environment.
interface deserializer_param_if #(
  parameter int WIDTH = 8
);
  logic             data_in;
  logic             write_in;
  logic             ack_in;
  logic [WIDTH-1:0] data_out;
  logic             data_ready;
  logic             status_out;
  logic             overrun;
  logic             parity_err;

  modport master (
    output data_in, write_in, ack_in,
    input  data_out, data_ready, status_out, overrun, parity_err
  );

  modport slave (
    input  data_in, write_in, ack_in,
    output data_out, data_ready, status_out, overrun, parity_err
  );
endinterface

// File: rtl/deserializer_param.sv
// Parametrised serial-to-parallel deserializer with a shift stage and a holding register.
// Define PARITY_CHECK_EN to append one even-parity bit to each frame and report parity_err.
//
// state | meaning
// RECV  | shift stage accepting write_in bits
// FULL  | complete word parked in shift stage, waiting for the holding register to free up
module deserializer_param #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input logic                 clk,
  input logic                 reset,
  deserializer_param_if.slave bus
);

`ifdef PARITY_CHECK_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);

  typedef enum logic {
    RECV = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_q, shift_nxt, word_done, data_q;
  logic             ready_q, status_q, overrun_q;
  logic             accept, data_bit, last_bit, hold_free;
  logic             load_new, load_parked;

  always_comb begin
    accept    = (state == RECV) && bus.write_in;
    data_bit  = (bit_cnt < CW'(WIDTH));
    last_bit  = accept && (bit_cnt == CW'(FRAME - 1));
    hold_free = !ready_q || bus.ack_in;
    if (MSB_FIRST) shift_nxt = {shift_q[WIDTH-2:0], bus.data_in};
    else           shift_nxt = {bus.data_in, shift_q[WIDTH-1:1]};
    // with parity the closing bit is not data, so the word is already complete
    word_done = data_bit ? shift_nxt : shift_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RECV;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_new    = 1'b0;
    load_parked = 1'b0;
    case (state)
      RECV: begin
        if (last_bit) begin
          if (hold_free) load_new  = 1'b1;
          else           state_nxt = FULL;
        end
      end
      FULL: begin
        if (bus.ack_in) begin
          load_parked = 1'b1;
          state_nxt   = RECV;
        end
      end
      default: state_nxt = RECV;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_cnt   <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      ready_q   <= 1'b0;
      status_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (accept && data_bit) shift_q <= shift_nxt;
      if (last_bit)    bit_cnt <= '0;
      else if (accept) bit_cnt <= bit_cnt + 1'b1;
      if (load_new || load_parked) begin
        data_q  <= load_new ? word_done : shift_q;
        ready_q <= 1'b1;
      end else if (bus.ack_in) begin
        ready_q <= 1'b0;
      end
      status_q  <= (state_nxt == FULL);
      overrun_q <= bus.write_in && status_q;
    end
  end

`ifdef PARITY_CHECK_EN
  logic par_acc, perr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_acc <= 1'b0;
      perr_q  <= 1'b0;
    end else if (load_new) begin
      perr_q  <= par_acc ^ bus.data_in;
      par_acc <= 1'b0;
    end else if (load_parked) begin
      perr_q  <= par_acc;
      par_acc <= 1'b0;
    end else if (accept) begin
      par_acc <= par_acc ^ bus.data_in;
    end
  end

  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.data_out   = data_q;
  assign bus.data_ready = ready_q;
  assign bus.status_out = status_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_deserializer_param.sv
// Bench for deserializer_param: LSB-first and MSB-first instances fed the same stream,
// checked every cycle against a word-level model plus literal expectations.
module tb_deserializer_param;
  localparam int W = 8;
`ifdef PARITY_CHECK_EN
  localparam int FRAME = W + 1;
`else
  localparam int FRAME = W;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic di = 1'b0, wi = 1'b0, ack = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  deserializer_param_if #(.WIDTH(W)) bus_l ();
  deserializer_param_if #(.WIDTH(W)) bus_m ();

  assign bus_l.data_in = di;  assign bus_l.write_in = wi;  assign bus_l.ack_in = ack;
  assign bus_m.data_in = di;  assign bus_m.write_in = wi;  assign bus_m.ack_in = ack;

  deserializer_param #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(bus_l));
  deserializer_param #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(bus_m));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // word-level model: a queue of received frame bits, a holding slot and a parked slot
  int         bits[$];
  logic       m_hv = 1'b0, m_pv = 1'b0, m_ovr = 1'b0, m_hpar = 1'b0, m_ppar = 1'b0;
  logic [7:0] m_hl = '0, m_hm = '0, m_pl = '0, m_pm = '0;

  always @(posedge clk or negedge reset) begin
    logic       got, par;
    logic [7:0] wl, wm;
    if (!reset) begin
      bits.delete();
      m_hv = 0; m_pv = 0; m_ovr = 0; m_hpar = 0; m_ppar = 0;
      m_hl = '0; m_hm = '0; m_pl = '0; m_pm = '0;
    end else begin
      got = 0; par = 0; wl = '0; wm = '0;
      m_ovr = wi && m_pv;
      if (m_pv) begin
        if (ack) begin
          m_hl = m_pl; m_hm = m_pm; m_hpar = m_ppar; m_pv = 0;
        end
      end else begin
        if (wi) bits.push_back(int'(di));
        if (bits.size() == FRAME) begin
          got = 1;
          for (int i = 0; i < FRAME; i++) par = par ^ bits[i][0];
          for (int i = 0; i < W; i++) begin
            wl[i]       = bits[i][0];
            wm[W-1-i]   = bits[i][0];
          end
          bits.delete();
        end
        if (got && (!m_hv || ack)) begin
          m_hl = wl; m_hm = wm; m_hpar = par; m_hv = 1;
        end else if (got) begin
          m_pl = wl; m_pm = wm; m_ppar = par; m_pv = 1;
        end else if (ack) begin
          m_hv = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic exp_perr;
`ifdef PARITY_CHECK_EN
    exp_perr = m_hpar;
`else
    exp_perr = 1'b0;
`endif
    chk("ready_l",   {31'd0, bus_l.data_ready}, {31'd0, m_hv});
    chk("ready_m",   {31'd0, bus_m.data_ready}, {31'd0, m_hv});
    chk("status_l",  {31'd0, bus_l.status_out}, {31'd0, m_pv});
    chk("status_m",  {31'd0, bus_m.status_out}, {31'd0, m_pv});
    chk("overrun_l", {31'd0, bus_l.overrun},    {31'd0, m_ovr});
    chk("overrun_m", {31'd0, bus_m.overrun},    {31'd0, m_ovr});
    if (m_hv) begin
      chk("data_l", {24'd0, bus_l.data_out}, {24'd0, m_hl});
      chk("data_m", {24'd0, bus_m.data_out}, {24'd0, m_hm});
      chk("perr_l", {31'd0, bus_l.parity_err}, {31'd0, exp_perr});
      chk("perr_m", {31'd0, bus_m.parity_err}, {31'd0, exp_perr});
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // one frame, LSB of word first; optional parity bit, ack on the last bit, idle gaps
  task automatic send_word(input logic [7:0] word, input logic par,
                           input logic ack_last, input int gap);
    for (int i = 0; i < FRAME; i++) begin
      wi  = 1'b1;
      di  = (i < W) ? word[i] : par;
      ack = ack_last && (i == FRAME - 1);
      step();
      wi  = 1'b0;
      ack = 1'b0;
      for (int g = 0; g < gap; g++) step();
    end
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    step();
    ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not end, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    step(); step();
    chk("rst_ready",  {31'd0, bus_l.data_ready}, 32'd0);
    chk("rst_status", {31'd0, bus_l.status_out}, 32'd0);
    chk("rst_data",   {24'd0, bus_l.data_out},   32'd0);
    chk("rst_perr",   {31'd0, bus_l.parity_err}, 32'd0);
    reset = 1'b1;
    step();

    // 1,0,1,1,0,0,1,0 stream
    send_word(8'h4D, 1'b0, 1'b0, 0);
    chk("lit_4d_l",     {24'd0, bus_l.data_out},   32'h4D);
    chk("lit_b2_m",     {24'd0, bus_m.data_out},   32'hB2);
    chk("lit_4d_ready", {31'd0, bus_l.data_ready}, 32'd1);
    chk("lit_4d_stat",  {31'd0, bus_l.status_out}, 32'd0);
    ack_pulse();
    chk("lit_ack_drop", {31'd0, bus_l.data_ready}, 32'd0);
    ack_pulse();
    chk("lit_idle_ack", {31'd0, bus_l.data_ready}, 32'd0);

    // gaps between bits
    send_word(8'h96, ^8'h96, 1'b0, 2);
    chk("lit_gap_96", {24'd0, bus_l.data_out}, 32'h96);
    ack_pulse();

    // back-pressure
    send_word(8'hA5, ^8'hA5, 1'b0, 0);
    send_word(8'h3C, ^8'h3C, 1'b0, 1);
    chk("lit_bp_a5",   {24'd0, bus_l.data_out},   32'hA5);
    chk("lit_bp_stat", {31'd0, bus_l.status_out}, 32'd1);
    wi = 1'b1; di = 1'b1;
    step();
    wi = 1'b0;
    chk("lit_ovr_on", {31'd0, bus_l.overrun}, 32'd1);
    step();
    chk("lit_ovr_off", {31'd0, bus_l.overrun}, 32'd0);
    ack_pulse();
    chk("lit_bp_3c",    {24'd0, bus_l.data_out},   32'h3C);
    chk("lit_bp_ready", {31'd0, bus_l.data_ready}, 32'd1);
    chk("lit_bp_free",  {31'd0, bus_l.status_out}, 32'd0);
    ack_pulse();

    // ack on the same edge as the last bit
    send_word(8'hA5, ^8'hA5, 1'b0, 0);
    send_word(8'h3C, ^8'h3C, 1'b1, 0);
    chk("lit_sim_3c",    {24'd0, bus_l.data_out},   32'h3C);
    chk("lit_sim_ready", {31'd0, bus_l.data_ready}, 32'd1);
    chk("lit_sim_stat",  {31'd0, bus_l.status_out}, 32'd0);
    ack_pulse();

    // reset mid-word
    send_word(8'h5A, 1'b0, 1'b0, 0);
    wi = 1'b1; di = 1'b1; step();
    di = 1'b0; step();
    di = 1'b1; step();
    wi = 1'b0;
    reset = 1'b0;
    #1;
    chk("lit_mr_ready", {31'd0, bus_l.data_ready}, 32'd0);
    chk("lit_mr_data",  {24'd0, bus_l.data_out},   32'd0);
    chk("lit_mr_stat",  {31'd0, bus_l.status_out}, 32'd0);
    chk("lit_mr_ovr",   {31'd0, bus_l.overrun},    32'd0);
    step(); step();
    reset = 1'b1;
    step();
    send_word(8'h4D, 1'b0, 1'b0, 0);
    chk("lit_mr_4d", {24'd0, bus_l.data_out}, 32'h4D);
    chk("lit_mr_b2", {24'd0, bus_m.data_out}, 32'hB2);
    ack_pulse();

`ifdef PARITY_CHECK_EN
    send_word(8'h4D, 1'b1, 1'b0, 0);
    chk("lit_par_bad", {31'd0, bus_l.parity_err}, 32'd1);
    chk("lit_par_dat", {24'd0, bus_l.data_out},   32'h4D);
    ack_pulse();
    send_word(8'h4D, 1'b0, 1'b0, 0);
    chk("lit_par_ok", {31'd0, bus_l.parity_err}, 32'd0);
    ack_pulse();
`endif

    step(); step(); step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
